// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: FSM state type and
// default widths / starvation bound.
package dmem_pkg;

  typedef enum logic {
    ARB      = 1'b0,
    AUX_RESP = 1'b1
  } arb_state_e;

  localparam int unsigned DW_DEF           = 16;
  localparam int unsigned AW_DEF           = 16;
  localparam int unsigned STARVE_LIMIT_DEF = 4;

endpackage

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter between the pipeline memory stage (CPU)
// and an auxiliary master. CPU has fixed priority; aux is forced through
// after STARVE_LIMIT consecutive denied cycles. Memory read is registered,
// so read data appears the cycle after the grant.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF,
  parameter int unsigned DW           = DW_DEF,
  parameter int unsigned AW           = AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_stall,
  output logic [DW-1:0] cpu_rdata,
  input  logic          aux_req,
  input  logic          aux_we,
  input  logic [AW-1:0] aux_addr,
  input  logic [DW-1:0] aux_wdata,
  output logic          aux_ack,
  output logic [DW-1:0] aux_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_write,
  input  logic [DW-1:0] mem_rdata
);

  localparam logic [3:0] LP_LIMIT = 4'(STARVE_LIMIT);

  arb_state_e r_state;
  logic [3:0] r_starve_cnt;
  logic       r_aux_ack;

  logic       w_limit_hit;
  logic       w_grant_aux;
  logic       w_grant_cpu;

  // Same-cycle grant decision; reset forces both grants low.
  always_comb begin
    w_limit_hit = (r_starve_cnt == LP_LIMIT);
    w_grant_aux = ~rst & aux_req & (r_state == ARB) & (~cpu_req | w_limit_hit);
    w_grant_cpu = ~rst & cpu_req & ~w_grant_aux;
  end

  // Steer the winning port onto the memory bus; writes only with a grant.
  always_comb begin
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    mem_write = cpu_we & w_grant_cpu;
    if (w_grant_aux) begin
      mem_addr  = aux_addr;
      mem_wdata = aux_wdata;
      mem_write = aux_we;
    end
  end

  // Arbitration FSM, starvation counter and registered aux acknowledge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ARB;
      r_starve_cnt <= '0;
      r_aux_ack    <= 1'b0;
    end else begin
      unique case (r_state)
        ARB: begin
          if (w_grant_aux) begin
            r_state      <= AUX_RESP;
            r_starve_cnt <= '0;
            r_aux_ack    <= 1'b1;
          end else begin
            r_aux_ack <= 1'b0;
            if (aux_req) begin
              if (!w_limit_hit) r_starve_cnt <= r_starve_cnt + 4'd1;
            end else begin
              r_starve_cnt <= '0;
            end
          end
        end
        AUX_RESP: begin
          r_state   <= ARB;
          r_aux_ack <= 1'b0;
        end
        default: begin
          r_state   <= ARB;
          r_aux_ack <= 1'b0;
        end
      endcase
    end
  end

  assign cpu_stall = cpu_req & ~w_grant_cpu;
  assign cpu_rdata = mem_rdata;
  assign aux_rdata = mem_rdata;
  assign aux_ack   = r_aux_ack;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios followed by a
// randomized phase, all compared against a cycle-level reference model.
module tb_dmem_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we;
  logic [15:0] cpu_addr, cpu_wdata;
  logic        cpu_stall;
  logic [15:0] cpu_rdata;
  logic        aux_req, aux_we;
  logic [15:0] aux_addr, aux_wdata;
  logic        aux_ack;
  logic [15:0] aux_rdata;
  logic [15:0] mem_addr, mem_wdata;
  logic        mem_write;
  logic [15:0] mem_rdata;

  dmem_arbiter #(.STARVE_LIMIT(LIMIT), .DW(16), .AW(16)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata),
    .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr), .aux_wdata(aux_wdata),
    .aux_ack(aux_ack), .aux_rdata(aux_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] init_val(input int unsigned a);
    return (a == 16) ? 16'hBEEF : 16'(a * 7 + 3);
  endfunction

  // Memory with one-cycle registered read (old data on read/write collision).
  logic [15:0] mem [65536];
  logic        mem_init;
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 65536; i++) mem[i] <= init_val(i);
    end else begin
      if (mem_write) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr];
    end
  end

  // Reference model state
  logic [15:0] shadow [65536];
  bit          m_resp;      // cycle following an aux grant
  int          m_denied;    // consecutive denied aux cycles, capped at LIMIT
  bit          m_ack_exp;
  bit          obs_stall, obs_mw;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: inputs already applied at the preceding negedge.
  task automatic cycle();
    bit ga, gc, cpu_rd, aux_rd;
    logic [15:0] ea, ew, rdv;
    bit emw;
    #2;
    if (rst) begin
      ga = 0; gc = 0;
    end else begin
      ga = aux_req && !m_resp && (!cpu_req || m_denied >= LIMIT);
      gc = cpu_req && !ga;
    end
    ea  = ga ? aux_addr  : cpu_addr;
    ew  = ga ? aux_wdata : cpu_wdata;
    emw = ga ? aux_we    : (cpu_we && gc);
    obs_stall = cpu_stall;
    obs_mw    = mem_write;
    chk("cpu_stall", cpu_stall, cpu_req && !gc);
    chk("mem_write", mem_write, emw);
    chk("mem_addr",  mem_addr,  ea);
    chk("mem_wdata", mem_wdata, ew);
    cpu_rd = gc && !cpu_we;
    aux_rd = ga && !aux_we;
    rdv = shadow[ea];
    if (emw) shadow[ea] = ew;
    if (rst) begin
      m_resp = 0; m_denied = 0; m_ack_exp = 0;
    end else if (m_resp) begin
      m_resp = 0; m_ack_exp = 0;
    end else if (ga) begin
      m_resp = 1; m_denied = 0; m_ack_exp = 1;
    end else begin
      m_ack_exp = 0;
      if (aux_req) m_denied = (m_denied + 1 > LIMIT) ? LIMIT : m_denied + 1;
      else         m_denied = 0;
    end
    @(posedge clk);
    #1;
    chk("aux_ack", aux_ack, m_ack_exp);
    if (cpu_rd) chk("cpu_rdata", cpu_rdata, rdv);
    if (aux_rd) chk("aux_rdata", aux_rdata, rdv);
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) shadow[i] = init_val(i);
    m_resp = 0; m_denied = 0; m_ack_exp = 0;
    mem_init = 1;
    rst = 1;
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0003; cpu_wdata = 16'h0;
    aux_req = 1; aux_we = 0; aux_addr = 16'h0004; aux_wdata = 16'h0;

    // Reset: grants forced low, stall follows cpu_req
    cycle();
    mem_init = 0;
    chk("rst_stall", obs_stall, 1'b1);
    chk("rst_ack", aux_ack, 1'b0);
    cycle();
    rst = 0; cpu_req = 0; aux_req = 0;
    cycle();

    // CPU-only read of preloaded word
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0010;
    cycle();
    chk("cpu_only_stall", obs_stall, 1'b0);
    chk("cpu_read_beef", cpu_rdata, 16'hBEEF);
    cpu_req = 0;

    // Aux write then read, request held across AUX_RESP
    aux_req = 1; aux_we = 1; aux_addr = 16'h0020; aux_wdata = 16'h1234;
    cycle();
    chk("aux_wr_mw", obs_mw, 1'b1);
    chk("aux_wr_ack", aux_ack, 1'b1);
    aux_we = 0;
    chk("aux_resp_no_grant", mem_write, 1'b0);
    cycle();
    chk("aux_ack_pulse", aux_ack, 1'b0);
    cycle();
    chk("aux_rd_ack", aux_ack, 1'b1);
    chk("aux_rd_data", aux_rdata, 16'h1234);
    aux_req = 0;
    cycle();

    // Contention: 4 CPU grants, aux grant, AUX_RESP with CPU granted
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0020;
    aux_req = 1; aux_we = 0; aux_addr = 16'h0010;
    for (int i = 0; i < 12; i++) begin
      cycle();
      chk("contend_stall", obs_stall, (i % 6) == 4);
      chk("contend_ack", aux_ack, (i % 6) == 4);
    end

    // Aux drops after 2 denials: counter restarts
    aux_req = 0;
    cycle();
    aux_req = 1;
    cycle(); cycle();
    aux_req = 0;
    cycle();
    aux_req = 1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("redeny_stall", obs_stall, i == 4);
    end
    aux_req = 0;
    cycle();

    // Reset in the cycle after an aux grant drops the transaction
    cpu_req = 0; aux_req = 1; aux_we = 0; aux_addr = 16'h0030;
    cycle();
    chk("pre_rst_ack", aux_ack, 1'b1);
    rst = 1; cpu_req = 1;
    cycle();
    chk("rst_mid_mw", obs_mw, 1'b0);
    chk("rst_mid_stall", obs_stall, 1'b1);
    chk("rst_mid_ack", aux_ack, 1'b0);
    rst = 0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("post_rst_stall", obs_stall, i == 4);
    end
    aux_req = 0; cpu_req = 0;
    cycle();

    // Randomized traffic following each port's handshake rules
    for (int n = 0; n < 800; n++) begin
      rst = ($urandom_range(0, 99) < 2);
      if (!(cpu_req && obs_stall)) begin
        cpu_req   = ($urandom_range(0, 99) < 60);
        cpu_we    = 1'($urandom);
        cpu_addr  = 16'($urandom_range(0, 31));
        cpu_wdata = 16'($urandom);
      end
      if (aux_req) begin
        if (aux_ack) aux_req = 0;
        else if ($urandom_range(0, 99) < 8) aux_req = 0;
      end else if ($urandom_range(0, 99) < 35) begin
        aux_req   = 1;
        aux_we    = 1'($urandom);
        aux_addr  = 16'($urandom_range(0, 31));
        aux_wdata = 16'($urandom);
      end
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
